// File: rtl/dcr_pkg.sv
// Shared definitions for the device control register bank: register map,
// STATUS bit positions and launch FSM state encoding.
package dcr_pkg;

    localparam int DCR_THREAD_COUNT = 0;
    localparam int DCR_BLOCK_DIM    = 1;
    localparam int DCR_PROG_BASE    = 2;
    localparam int DCR_CTRL         = 3;
    localparam int DCR_STATUS       = 4;
    localparam int DCR_SCRATCH0     = 5;

    localparam int CTRL_LAUNCH_BIT  = 0;
    localparam int ST_BUSY_BIT      = 0;
    localparam int ST_DONE_BIT      = 1;
    localparam int ST_ERR_BIT       = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } dcr_state_e;

endpackage

// File: rtl/dcr_launch_fsm.sv
// Launch handshake to the dispatcher: one-cycle kernel_start, busy until
// kernel_done is seen in RUN, and a done-set strobe for STATUS.
module dcr_launch_fsm (
    input  logic clk,
    input  logic rst_n,
    input  logic launch_i,
    input  logic kernel_done_i,
    output logic busy_o,
    output logic kernel_start_o,
    output logic done_set_o
);
    import dcr_pkg::*;

    dcr_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch_i) state_d = LAUNCH;
            LAUNCH:  state_d = RUN;
            RUN:     if (kernel_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from the state register so reset drops them at once.
    always_comb begin
        busy_o         = (state_q != IDLE);
        kernel_start_o = (state_q == LAUNCH);
        done_set_o     = (state_q == RUN) && kernel_done_i;
    end

endmodule

// File: rtl/dcr_bank.sv
// Device control register bank: launch config, CTRL/STATUS and scratch
// registers behind an addressed port, with config locked while a kernel runs.
module dcr_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  device_control_write_enable,
    input  logic [ADDR_WIDTH-1:0] device_control_addr,
    input  logic [DATA_WIDTH-1:0] device_control_data,
    input  logic                  device_control_read_enable,
    output logic [DATA_WIDTH-1:0] device_control_read_data,
    output logic                  device_control_read_valid,
    output logic                  write_error,
    output logic [DATA_WIDTH-1:0] thread_count,
    output logic [DATA_WIDTH-1:0] block_dim,
    output logic [DATA_WIDTH-1:0] prog_base,
    output logic                  kernel_start,
    input  logic                  kernel_done,
    output logic                  busy
);
    import dcr_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] A_PB     = ADDR_WIDTH'(DCR_PROG_BASE);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(DCR_CTRL);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(DCR_STATUS);
    localparam logic [ADDR_WIDTH-1:0] A_SCR    = ADDR_WIDTH'(DCR_SCRATCH0);
    localparam logic [ADDR_WIDTH:0]   NREGS    = (ADDR_WIDTH+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_q, rd_d, status_val;
    logic rv_q, werr_q, done_q, done_d, err_q, err_d;
    logic in_range, is_cfg, is_scr, launch_req, tc_zero, reject, launch_ok;
    logic st_wr, done_set;

    dcr_launch_fsm u_fsm (
        .clk           (clk),
        .rst_n         (reset),
        .launch_i      (launch_ok),
        .kernel_done_i (kernel_done),
        .busy_o        (busy),
        .kernel_start_o(kernel_start),
        .done_set_o    (done_set)
    );

    always_comb begin
        in_range   = ({1'b0, device_control_addr} < NREGS);
        is_cfg     = (device_control_addr <= A_PB);
        is_scr     = in_range && (device_control_addr >= A_SCR);
        launch_req = device_control_write_enable && (device_control_addr == A_CTRL)
                     && device_control_data[CTRL_LAUNCH_BIT];
        tc_zero    = (regs_q[DCR_THREAD_COUNT] == '0);
        reject     = device_control_write_enable &&
                     (!in_range || (is_cfg && busy) || (launch_req && (busy || tc_zero)));
        launch_ok  = launch_req && !busy && !tc_zero;
        st_wr      = device_control_write_enable && (device_control_addr == A_STATUS);

        regs_d = regs_q;
        if (device_control_write_enable && ((is_cfg && !busy) || is_scr))
            regs_d[device_control_addr] = device_control_data;

        // A sticky set in the same cycle as its W1C clear must win.
        done_d = done_set | (done_q & ~(st_wr & device_control_data[ST_DONE_BIT]));
        err_d  = reject   | (err_q  & ~(st_wr & device_control_data[ST_ERR_BIT]));

        status_val              = '0;
        status_val[ST_BUSY_BIT] = busy;
        status_val[ST_DONE_BIT] = done_q;
        status_val[ST_ERR_BIT]  = err_q;

        // Reads see pre-write state, so same-cycle read/write returns the old value.
        rd_d = rd_q;
        if (device_control_read_enable) begin
            if (!in_range || device_control_addr == A_CTRL) rd_d = '0;
            else if (device_control_addr == A_STATUS)       rd_d = status_val;
            else                                            rd_d = regs_q[device_control_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            rd_q   <= '0;
            rv_q   <= 1'b0;
            werr_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            rd_q   <= rd_d;
            rv_q   <= device_control_read_enable;
            werr_q <= reject;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign device_control_read_data  = rd_q;
    assign device_control_read_valid = rv_q;
    assign write_error               = werr_q;
    assign thread_count              = regs_q[DCR_THREAD_COUNT];
    assign block_dim                 = regs_q[DCR_BLOCK_DIM];
    assign prog_base                 = regs_q[DCR_PROG_BASE];

endmodule
